// File: rtl/jtag_tap_ir_pkg.sv
// Shared TAP definitions: the fixed 4-bit state codes, capture constant and the
// TMS-driven next-state rule used by the controller.
package jtag_tap_ir_pkg;

  typedef enum logic [3:0] {
    ST_EXIT2_DR   = 4'h0,
    ST_EXIT1_DR   = 4'h1,
    ST_SHIFT_DR   = 4'h2,
    ST_PAUSE_DR   = 4'h3,
    ST_SEL_IR     = 4'h4,
    ST_UPDATE_DR  = 4'h5,
    ST_CAPTURE_DR = 4'h6,
    ST_SEL_DR     = 4'h7,
    ST_EXIT2_IR   = 4'h8,
    ST_EXIT1_IR   = 4'h9,
    ST_SHIFT_IR   = 4'hA,
    ST_PAUSE_IR   = 4'hB,
    ST_RTI        = 4'hC,
    ST_UPDATE_IR  = 4'hD,
    ST_CAPTURE_IR = 4'hE,
    ST_TLR        = 4'hF
  } tap_state_t;

  // Fixed low bits loaded into the IR on capture, as required by 1149.1.
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      ST_TLR:        n = tms ? ST_TLR       : ST_RTI;
      ST_RTI:        n = tms ? ST_SEL_DR    : ST_RTI;
      ST_SEL_DR:     n = tms ? ST_SEL_IR    : ST_CAPTURE_DR;
      ST_CAPTURE_DR: n = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_SHIFT_DR:   n = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
      ST_EXIT1_DR:   n = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
      ST_PAUSE_DR:   n = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
      ST_EXIT2_DR:   n = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
      ST_UPDATE_DR:  n = tms ? ST_SEL_DR    : ST_RTI;
      ST_SEL_IR:     n = tms ? ST_TLR       : ST_CAPTURE_IR;
      ST_CAPTURE_IR: n = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_SHIFT_IR:   n = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
      ST_EXIT1_IR:   n = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
      ST_PAUSE_IR:   n = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
      ST_EXIT2_IR:   n = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
      ST_UPDATE_IR:  n = tms ? ST_SEL_DR    : ST_RTI;
      default:       n = ST_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_ir_tap_fsm.sv
// 16-state TAP controller: advances on every TCK rise from TMS, asynchronously
// forced to Test-Logic-Reset by reset_bar.
module tap_fsm
  import jtag_tap_ir_pkg::*;
(
  input  logic       TCK,
  input  logic       reset_bar,
  input  logic       TMS,
  output logic [3:0] tap_state
);

  tap_state_t state_q;

  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= tap_next(state_q, TMS);
    end
  end

  assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_ir.sv
// TAP controller with instruction register: IR capture/shift/update, DR-side
// enables, instruction select decode and the TDO mux.
module jtag_tap_ir
  import jtag_tap_ir_pkg::*;
#(
  parameter int unsigned        IR_size   = 4,
  parameter logic [IR_size-1:0] IDCODE_op = {{(IR_size-1){1'b0}}, 1'b1},
  parameter logic [IR_size-1:0] BYPASS_op = '1,
  parameter logic [IR_size-1:0] EXTEST_op = '0
) (
  input  logic               TCK,
  input  logic               reset_bar,
  input  logic               TMS,
  input  logic               TDI,
  input  logic [IR_size-1:0] ir_status,
  input  logic               tdo_dr,
  output logic               TDO,
  output logic               tdo_enable,
  output logic [IR_size-1:0] instruction,
  output logic [3:0]         tap_state,
  output logic               capture_dr,
  output logic               shift_dr,
  output logic               update_dr,
  output logic               sel_bypass,
  output logic               sel_idcode,
  output logic               sel_extest
);

  logic [3:0]         state_code;
  tap_state_t         state;
  logic [IR_size-1:0] capture_val;
  logic [IR_size-1:0] ir_shift_q, ir_shift_d;
  logic [IR_size-1:0] instr_q, instr_d;
  logic               unused_status_bits;

  tap_fsm u_tap_fsm (
    .TCK       (TCK),
    .reset_bar (reset_bar),
    .TMS       (TMS),
    .tap_state (state_code)
  );

  assign state = tap_state_t'(state_code);

  // The two low status bits are replaced by the mandatory 01 capture pattern.
  assign unused_status_bits = ^ir_status[1:0];
  if (IR_size > 2) begin : g_wide_capture
    assign capture_val = {ir_status[IR_size-1:2], IR_CAPTURE_LSBS};
  end else begin : g_min_capture
    assign capture_val = IR_CAPTURE_LSBS;
  end

  always_comb begin
    ir_shift_d = ir_shift_q;
    instr_d    = instr_q;
    case (state)
      ST_CAPTURE_IR: ir_shift_d = capture_val;
      ST_SHIFT_IR:   ir_shift_d = {TDI, ir_shift_q[IR_size-1:1]};
      ST_UPDATE_IR:  instr_d    = ir_shift_q;
      ST_TLR:        instr_d    = IDCODE_op;
      default:       ;
    endcase
  end

  // Reset restores IDCODE at once, so the DR side never sees a stale opcode.
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      ir_shift_q <= '0;
      instr_q    <= IDCODE_op;
    end else begin
      ir_shift_q <= ir_shift_d;
      instr_q    <= instr_d;
    end
  end

  always_comb begin
    TDO        = 1'b0;
    tdo_enable = 1'b0;
    case (state)
      ST_SHIFT_IR: begin
        TDO        = ir_shift_q[0];
        tdo_enable = 1'b1;
      end
      ST_SHIFT_DR: begin
        TDO        = tdo_dr;
        tdo_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign capture_dr  = (state == ST_CAPTURE_DR);
  assign shift_dr    = (state == ST_SHIFT_DR);
  assign update_dr   = (state == ST_UPDATE_DR);

  assign instruction = instr_q;
  assign tap_state   = state_code;

  // Unknown opcodes leave every select low; the DR fabric falls back to bypass.
  assign sel_bypass  = (instr_q == BYPASS_op);
  assign sel_idcode  = (instr_q == IDCODE_op);
  assign sel_extest  = (instr_q == EXTEST_op);

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Bench for jtag_tap_ir: directed scenarios plus random TMS/TDI traffic checked
// against a table-driven TAP model with an integer IR model.
`timescale 1ns/1ps
module tb_jtag_tap_ir;

  logic       TCK = 1'b0;
  logic       reset_bar, TMS, TDI, tdo_dr;
  logic [3:0] ir_status;
  logic       TDO, tdo_enable;
  logic [3:0] instruction, tap_state;
  logic       capture_dr, shift_dr, update_dr, sel_bypass, sel_idcode, sel_extest;
  logic [15:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  logic [6:0] path_bits [16];
  int         path_len  [16];
  logic [3:0] m_state, m_ir, m_instr;

  jtag_tap_ir #(.IR_size(4)) dut (
    .TCK(TCK), .reset_bar(reset_bar), .TMS(TMS), .TDI(TDI),
    .ir_status(ir_status), .tdo_dr(tdo_dr), .TDO(TDO), .tdo_enable(tdo_enable),
    .instruction(instruction), .tap_state(tap_state), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .sel_bypass(sel_bypass),
    .sel_idcode(sel_idcode), .sel_extest(sel_extest)
  );

  always #5 TCK = ~TCK;

  assign dut_vec = {tap_state, TDO, tdo_enable, instruction, capture_dr, shift_dr,
                    update_dr, sel_bypass, sel_idcode, sel_extest};

  function automatic logic [15:0] exp_vec();
    logic sh_ir, sh_dr, tdo;
    sh_ir = (m_state == 4'hA);
    sh_dr = (m_state == 4'h2);
    tdo   = sh_ir ? m_ir[0] : (sh_dr ? tdo_dr : 1'b0);
    return {m_state, tdo, sh_ir | sh_dr, m_instr, m_state == 4'h6, sh_dr,
            m_state == 4'h5, m_instr == 4'hF, m_instr == 4'h1, m_instr == 4'h0};
  endfunction

  task automatic model_reset();
    m_state = 4'hF;
    m_ir    = 4'h0;
    m_instr = 4'h1;
  endtask

  // One TCK cycle: drive, let the edge happen, advance the model, settle.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    case (m_state)
      4'hE:    m_ir = (ir_status & 4'hC) | 4'h1;
      4'hA:    m_ir = (m_ir >> 1) | (tdi ? 4'h8 : 4'h0);
      4'hD:    m_instr = m_ir;
      4'hF:    m_instr = 4'h1;
      default: ;
    endcase
    m_state = tms ? nx1[m_state] : nx0[m_state];
    #1;
  endtask

  task automatic load_ir(input logic [3:0] v);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_bar = 1'b1; TMS = 1'b1; TDI = 1'b0; tdo_dr = 1'b0; ir_status = 4'h0;
    #5 reset_bar = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (tap_state !== 4'hF) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", tap_state, 4'hF);
    end
    n_checks++;
    if (instruction !== 4'h1) begin
      n_fail++; $display("FAIL reset_instr: got %h expected %h", instruction, 4'h1);
    end
    n_checks++;
    if ({TDO, tdo_enable, capture_dr, shift_dr, update_dr} !== 5'b0) begin
      n_fail++; $display("FAIL reset_enables: got %b expected 00000",
                         {TDO, tdo_enable, capture_dr, shift_dr, update_dr});
    end
    @(negedge TCK);
    reset_bar = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_hold: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  // Every state is reached by a known TMS path, then both arcs out of it are taken.
  task automatic test_fsm_sweep();
    for (int s = 0; s < 16; s++) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < path_len[s]; i++) tick(path_bits[s][i], 1'b0);
        n_checks++;
        if (tap_state !== 4'(s)) begin
          n_fail++; $display("FAIL sweep_reach: got %h expected %h", tap_state, 4'(s));
        end
        tick(b[0], 1'b0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++; $display("FAIL sweep_arc s=%0d tms=%0d: got %h expected %h",
                             s, b, dut_vec, exp_vec());
        end
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        n_checks++;
        if (tap_state !== 4'hF) begin
          n_fail++; $display("FAIL sweep_tlr s=%0d: got %h expected f", s, tap_state);
        end
      end
    end
  endtask

  task automatic test_ir_shift();
    logic [3:0] tdi_pat, tdo_pat;
    tdi_pat = 4'b1010;
    tdo_pat = 4'b1101;
    ir_status = 4'hC;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'hA || tdo_enable !== 1'b1) begin
      n_fail++; $display("FAIL ir_enter_shift: got %h/%b expected a/1", tap_state, tdo_enable);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (TDO !== tdo_pat[i]) begin
        n_fail++; $display("FAIL ir_tdo bit%0d: got %b expected %b", i, TDO, tdo_pat[i]);
      end
      tick(i == 3, tdi_pat[i]);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (tap_state !== 4'hD || instruction !== 4'h1) begin
      n_fail++; $display("FAIL ir_in_update: got %h/%h expected d/1", tap_state, instruction);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (instruction !== 4'b1010) begin
      n_fail++; $display("FAIL ir_update: got %b expected 1010", instruction);
    end
  endtask

  task automatic test_bypass_dr();
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    n_checks++;
    if ({instruction, sel_bypass, sel_idcode, sel_extest} !== 7'b1111_100) begin
      n_fail++; $display("FAIL bypass_sel: got %b expected 1111100",
                         {instruction, sel_bypass, sel_idcode, sel_extest});
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if ({capture_dr, shift_dr, update_dr} !== 3'b100) begin
      n_fail++; $display("FAIL dr_capture: got %b expected 100", {capture_dr, shift_dr, update_dr});
    end
    tick(1'b0, 1'b0);
    tdo_dr = 1'b1;
    #1;
    n_checks++;
    if ({TDO, tdo_enable, shift_dr} !== 3'b111) begin
      n_fail++; $display("FAIL dr_shift_hi: got %b expected 111", {TDO, tdo_enable, shift_dr});
    end
    tdo_dr = 1'b0;
    #1;
    n_checks++;
    if ({TDO, tdo_enable, shift_dr} !== 3'b011) begin
      n_fail++; $display("FAIL dr_shift_lo: got %b expected 011", {TDO, tdo_enable, shift_dr});
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    n_checks++;
    if ({capture_dr, shift_dr, update_dr, tdo_enable} !== 4'b0010) begin
      n_fail++; $display("FAIL dr_update: got %b expected 0010",
                         {capture_dr, shift_dr, update_dr, tdo_enable});
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_pause_ir();
    ir_status = 4'h4;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'hB || instruction !== 4'hF) begin
      n_fail++; $display("FAIL pause_hold: got %h/%h expected b/f", tap_state, instruction);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (tap_state !== 4'hA || TDO !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume: got %h/%b expected a/1", tap_state, TDO);
    end
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    n_checks++;
    if (instruction !== 4'hF) begin
      n_fail++; $display("FAIL pause_early_update: got %h expected f", instruction);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (instruction !== 4'b0110) begin
      n_fail++; $display("FAIL pause_result: got %b expected 0110", instruction);
    end
  endtask

  task automatic test_async_reset();
    load_ir(4'h0);
    n_checks++;
    if (instruction !== 4'h0 || sel_extest !== 1'b1 || sel_idcode !== 1'b0) begin
      n_fail++; $display("FAIL extest_sel: got %h/%b/%b expected 0/1/0",
                         instruction, sel_extest, sel_idcode);
    end
    ir_status = 4'hB;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b1); tick(1'b0, 1'b0);
    #2 reset_bar = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({tap_state, instruction, TDO, update_dr} !== {4'hF, 4'h1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h",
                         {tap_state, instruction, TDO, update_dr}, {4'hF, 4'h1, 2'b00});
    end
    @(negedge TCK);
    reset_bar = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL async_after: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      ir_status = 4'($urandom);
      tdo_dr    = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset_bar = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++; $display("FAIL random_reset c=%0d: got %h expected %h", c, dut_vec, exp_vec());
        end
        reset_bar = 1'b1;
        #1;
      end
      tick($urandom_range(0, 99) < 35, 1'($urandom));
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random c=%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nx0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nx1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    path_bits = '{7'h2A, 7'h0A, 7'h02, 7'h0A, 7'h06, 7'h1A, 7'h02, 7'h02,
                  7'h56, 7'h16, 7'h06, 7'h16, 7'h00, 7'h36, 7'h06, 7'h00};
    path_len  = '{6, 4, 4, 5, 3, 5, 3, 2, 7, 5, 5, 6, 1, 6, 4, 0};
    model_reset();
    test_reset();
    test_fsm_sweep();
    test_ir_shift();
    test_bypass_dr();
    test_pause_ir();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
